// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - RV32M multiply/divide execute unit (iterative shift-add / restoring divide)
// Optional MULDIV_FAST_MUL_EN: single-cycle 33x33 signed multiplier for all multiplies.
module ex_muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_addr,
  output logic            stall_req,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [2:0]          op_q;
  logic [4:0]          rd_q;
  logic [XLEN-1:0]     opnd_q;
  logic [2*XLEN-1:0]   work_q;
  logic                neg_res_q, neg_rem_q;
  logic [XLEN-1:0]     result_q;
  logic [4:0]          rd_out_q;

  logic                accept, is_div, a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0]     a_mag, b_mag;
  logic                div_by_zero, div_ovf, take_short;
  logic [XLEN-1:0]     short_res;

  assign accept   = (state_q == S_IDLE) && start && !flush;
  assign is_div   = func3[2];
  assign a_signed = !(func3 inside {3'b011, 3'b101, 3'b111});
  assign b_signed = func3 inside {3'b000, 3'b001, 3'b100, 3'b110};
  assign a_neg    = a_signed && rs1_data[XLEN-1];
  assign b_neg    = b_signed && rs2_data[XLEN-1];
  assign a_mag    = a_neg ? (~rs1_data + 1'b1) : rs1_data;
  assign b_mag    = b_neg ? (~rs2_data + 1'b1) : rs2_data;

  assign div_by_zero = is_div && (rs2_data == '0);
  assign div_ovf     = is_div && !func3[0] && (rs1_data == {1'b1, {(XLEN-1){1'b0}}})
                       && (rs2_data == '1);

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_a, fast_b, fast_p;
  assign fast_a     = {{XLEN{a_signed && rs1_data[XLEN-1]}}, rs1_data};
  assign fast_b     = {{XLEN{b_signed && rs2_data[XLEN-1]}}, rs2_data};
  assign fast_p     = fast_a * fast_b;
  assign take_short = div_by_zero || div_ovf || !is_div;
`else
  assign take_short = div_by_zero || div_ovf;
`endif

  always_comb begin
    short_res = '0;
    if (div_by_zero)
      short_res = func3[1] ? rs1_data : '1;
    else if (div_ovf)
      short_res = func3[1] ? '0 : rs1_data;
`ifdef MULDIV_FAST_MUL_EN
    else if (!is_div)
      short_res = (func3 == 3'b000) ? fast_p[XLEN-1:0] : fast_p[2*XLEN-1:XLEN];
`endif
  end

  // One iteration step: multiply accumulates into the upper half while the
  // multiplier shifts out below; divide shifts the dividend into the remainder.
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0] work_nxt;

  always_comb begin
    mul_sum   = {1'b0, work_q[2*XLEN-1:XLEN]} + (work_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {work_q[2*XLEN-1:XLEN], work_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    if (!op_q[2])
      work_nxt = {mul_sum, work_q[XLEN-1:1]};
    else if (!div_diff[XLEN])
      work_nxt = {div_diff[XLEN-1:0], work_q[XLEN-2:0], 1'b1};
    else
      work_nxt = {div_shift[XLEN-1:0], work_q[XLEN-2:0], 1'b0};
  end

  logic [2*XLEN-1:0] mul_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, final_res;

  always_comb begin
    mul_fix   = neg_res_q ? (~work_nxt + 1'b1) : work_nxt;
    quo_fix   = neg_res_q ? (~work_nxt[XLEN-1:0] + 1'b1) : work_nxt[XLEN-1:0];
    rem_fix   = neg_rem_q ? (~work_nxt[2*XLEN-1:XLEN] + 1'b1) : work_nxt[2*XLEN-1:XLEN];
    final_res = '0;
    case (op_q)
      3'b000:                 final_res = mul_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: final_res = mul_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         final_res = quo_fix;
      default:                final_res = rem_fix;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = take_short ? S_DONE : S_BUSY;
      S_BUSY: begin
        if (flush)                 state_d = S_IDLE;
        else if (cnt_q == CNT_LAST) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    stall_req = accept || (state_q == S_BUSY);
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      op_q      <= '0;
      rd_q      <= '0;
      opnd_q    <= '0;
      work_q    <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
      rd_out_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            op_q      <= func3;
            rd_q      <= rd_addr;
            opnd_q    <= is_div ? b_mag : a_mag;
            work_q    <= {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
            neg_res_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            if (take_short) begin
              result_q <= short_res;
              rd_out_q <= rd_addr;
            end
          end
        end
        S_BUSY: begin
          if (flush) begin
            cnt_q <= '0;
          end else if (cnt_q == CNT_LAST) begin
            cnt_q    <= '0;
            work_q   <= work_nxt;
            result_q <= final_res;
            rd_out_q <= rd_q;
          end else begin
            cnt_q  <= cnt_q + 1'b1;
            work_q <= work_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  assign result = result_q;
  assign rd_out = rd_out_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb/tb_ex_muldiv_unit.sv - randomized self-checking bench for ex_muldiv_unit against an arithmetic model
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n, start, flush;
  logic [2:0]  func3;
  logic [31:0] rs1_data, rs2_data;
  logic [4:0]  rd_addr;
  logic        stall_req, busy, done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  always #5 clk = ~clk;

  ex_muldiv_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .flush(flush), .func3(func3),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_addr(rd_addr),
    .stall_req(stall_req), .busy(busy), .done(done), .result(result), .rd_out(rd_out)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] last_res = '0;
  logic [4:0]  last_rd  = '0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    logic ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'({32'b0, a});
    ub  = longint'({32'b0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = '0;
    case (f)
      3'd0: begin p = sa * sb; return p[31:0];  end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf)    return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (ovf)    return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  function automatic int exp_latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && b == 0) return 1;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MULDIV_FAST_MUL_EN
    if (!f[2]) return 1;
`endif
    return 33;
  endfunction

  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input bit hold);
    logic [31:0] expv;
    int lat, cyc;
    expv = model(f, a, b);
    lat  = exp_latency(f, a, b);
    @(negedge clk);
    func3 = f; rs1_data = a; rs2_data = b; rd_addr = rd; flush = 1'b0; start = 1'b1;
    #1 check_eq({tag, ":stall_T"}, 32'(stall_req), 32'd1);
    for (cyc = 1; cyc <= 100; cyc++) begin
      @(posedge clk); #1;
      if (!hold && cyc == 1) start = 1'b0;
      if (done) break;
      if (!stall_req || !busy) check_eq({tag, ":busy_stall"}, {busy, stall_req}, 2'b11);
    end
    check_eq({tag, ":latency"}, 32'(cyc), 32'(lat));
    check_eq({tag, ":result"}, result, expv);
    check_eq({tag, ":rd_out"}, 32'(rd_out), 32'(rd));
    check_eq({tag, ":stall_done"}, 32'(stall_req), 32'd0);
    start = 1'b0;
    @(posedge clk); #1;
    check_eq({tag, ":after_done"}, {30'b0, done, busy}, 32'd0);
    last_res = expv;
    last_rd  = rd;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h1;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    int ndone;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; func3 = '0;
    rs1_data = '0; rs2_data = '0; rd_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_outs", {stall_req, busy, done, rd_out}, '0);
    check_eq("reset_result", result, '0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("mul_7xm3", 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd11, 1'b0);
    run_op("mulhu_ff", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 1'b0);
    run_op("mulh_ff", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 1'b0);
    run_op("mulhsu_ff", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 1'b0);
    run_op("mul_ff", 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 1'b0);
    run_op("div_m7_2", 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd5, 1'b0);
    run_op("rem_m7_2", 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6, 1'b0);
    run_op("divu_2", 3'd5, 32'hFFFF_FFF9, 32'd2, 5'd7, 1'b0);
    run_op("remu_2", 3'd7, 32'hFFFF_FFF9, 32'd2, 5'd8, 1'b0);
    run_op("divu_by0", 3'd5, 32'd5, 32'd0, 5'd9, 1'b0);
    run_op("rem_by0", 3'd6, 32'd5, 32'd0, 5'd10, 1'b0);
    run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 1'b0);
    run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 1'b0);
    run_op("mulh_min", 3'd1, 32'h8000_0000, 32'h8000_0000, 5'd14, 1'b0);
    run_op("hold_div", 3'd4, 32'd100, 32'd7, 5'd15, 1'b1);
    run_op("hold_by0", 3'd7, 32'd9, 32'd0, 5'd16, 1'b1);

    // Flush a divide in flight: no done, outputs keep the previous result.
    @(negedge clk);
    func3 = 3'd4; rs1_data = 32'd1000; rs2_data = 32'd3; rd_addr = 5'd20; start = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      @(posedge clk); #1;
      if (k == 1)  start = 1'b0;
      if (k == 10) flush = 1'b1;
    end
    check_eq("flush_idle", {busy, stall_req}, 2'b00);
    flush = 1'b0;
    ndone = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check_eq("flush_no_done", 32'(ndone), 32'd0);
    check_eq("flush_res_hold", result, last_res);
    check_eq("flush_rd_hold", 32'(rd_out), 32'(last_rd));
    run_op("mul_3x4", 3'd0, 32'd3, 32'd4, 5'd21, 1'b0);

    // Reset mid-op clears everything.
    @(negedge clk);
    func3 = 3'd6; rs1_data = 32'd77; rs2_data = 32'd5; rd_addr = 5'd22; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    check_eq("rst_mid_outs", {stall_req, busy, done, rd_out}, '0);
    check_eq("rst_mid_result", result, '0);
    rst_n = 1'b1;
    run_op("mul_after_rst", 3'd0, 32'd3, 32'd4, 5'd23, 1'b0);

    for (int i = 0; i < 60; i++) begin
      logic [2:0]  f;
      logic [31:0] a, b;
      f = 3'($urandom_range(0, 7));
      a = pick_operand();
      b = pick_operand();
      run_op($sformatf("rnd%0d_f%0d", i, f), f, a, b, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
